// File: rtl/uart_sim_mmio.sv
// rtl/uart_sim_mmio.sv - memory-mapped simulation UART: TX FIFO drained at a fixed character rate
// Optional console echo of each transmitted byte: define UART_SIM_CONSOLE_EN
module uart_sim_mmio #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CHAR_CYCLES = 10,
  parameter int CNT_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        gnt,
  output logic        rvalid,
  output logic        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CHAR_CYCLES + 1);

  localparam logic [5:0] OFF_TXDATA  = 6'd0;
  localparam logic [5:0] OFF_STATUS  = 6'd1;
  localparam logic [5:0] OFF_CTRL    = 6'd2;
  localparam logic [5:0] OFF_CHARCNT = 6'd3;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          fifo_count;
  logic [BW-1:0]        busy_cnt;
  logic                 overflow;
  logic                 tx_enable;
  logic [CNT_WIDTH-1:0] char_count;

  logic [5:0]  off;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tx_busy;
  logic        pop;
  logic        push_req;
  logic        push;
  logic        ctrl_wr;
  logic        known_off;
  logic [31:0] read_val;
  logic        unused_bits;

  assign gnt         = req;
  assign off         = addr[7:2];
  assign unused_bits = ^{addr[31:8], addr[1:0], be[3:1], wdata[31:8]};

  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign tx_busy    = (busy_cnt != '0);

  // A pop frees a slot in the same cycle, so a push to a full FIFO that is popping is accepted
  assign pop      = tx_enable && !fifo_empty && !tx_busy;
  assign push_req = req && we && (off == OFF_TXDATA) && be[0];
  assign push     = push_req && (!fifo_full || pop);
  assign ctrl_wr  = req && we && (off == OFF_CTRL);

  // Register read mux; values reflect state before this cycle's update
  always_comb begin
    read_val  = '0;
    known_off = 1'b1;
    case (off)
      OFF_TXDATA: read_val = '0;
      OFF_STATUS: begin
        read_val[0]    = fifo_full;
        read_val[1]    = fifo_empty;
        read_val[2]    = tx_busy;
        read_val[3]    = overflow;
        read_val[15:8] = 8'(fifo_count);
      end
      OFF_CTRL:    read_val[0] = tx_enable;
      OFF_CHARCNT: read_val = 32'(char_count);
      default:     known_off = 1'b0;
    endcase
  end

  // Bus response: one cycle after every request; rdata/err hold between responses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= req;
      if (req) begin
        rdata <= we ? 32'h0 : read_val;
        err   <= !known_off;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmitter: busy counter covers one character time after each pop
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_cnt   <= '0;
      char_count <= '0;
    end else if (pop) begin
      busy_cnt   <= BW'(CHAR_CYCLES);
      char_count <= char_count + CNT_WIDTH'(1);
    end else if (tx_busy) begin
      busy_cnt   <= busy_cnt - BW'(1);
    end
  end

  // Control and sticky overflow; a same-cycle set beats the clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_enable <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      if (ctrl_wr) tx_enable <= wdata[0];
      if (push_req && !push)       overflow <= 1'b1;
      else if (ctrl_wr && wdata[1]) overflow <= 1'b0;
    end
  end

`ifdef UART_SIM_CONSOLE_EN
  // Echo each transmitted byte
  always_ff @(posedge clk) begin
    if (resetn && pop) begin
      $write("%c", mem[rd_ptr]);
    end
  end
`endif

endmodule

// File: tb/tb_uart_sim_mmio.sv
// tb/tb_uart_sim_mmio.sv - randomized self-checking bench for uart_sim_mmio
module tb_uart_sim_mmio;
  localparam int DEPTH = 16;
  localparam int CHARC = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        gnt;
  logic        rvalid;
  logic        err;

  int checks = 0;
  int errors = 0;

  // behavioural model: byte queue plus the cycle at which the transmitter frees up
  logic [7:0]  q[$];
  logic        m_ovf;
  logic        m_en;
  logic [31:0] m_cc;
  longint      cyc_n;
  longint      busy_until;

  logic        exp_v, exp_e, obs_v, obs_e;
  logic [31:0] exp_d, obs_d;

  uart_sim_mmio #(.FIFO_DEPTH(DEPTH), .CHAR_CYCLES(CHARC), .CNT_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .req(req), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .rdata(rdata), .gnt(gnt), .rvalid(rvalid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_addr(input logic [5:0] o);
    logic [31:0] rnd;
    rnd = $urandom;
    return {rnd[31:8], o, rnd[1:0]};
  endfunction

  // One bus cycle: drive, predict from the model, advance the model, sample after the edge
  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    logic [5:0]  o;
    logic [31:0] val;
    logic        busy;
    logic        popping;
    logic [7:0]  dummy;
    req = r; we = w; addr = a; be = b; wdata = d;
    o = a[7:2];
    busy = (cyc_n < busy_until);
    val = 32'h0;
    case (o)
      6'd1: val = {16'h0, 8'(q.size()), 4'h0, m_ovf, busy, (q.size() == 0), (q.size() == DEPTH)};
      6'd2: val = {31'h0, m_en};
      6'd3: val = m_cc;
      default: val = 32'h0;
    endcase
    exp_v = r;
    if (r) begin
      exp_d = w ? 32'h0 : val;
      exp_e = (o > 6'd3);
    end
    popping = m_en && (q.size() > 0) && !busy;
    if (popping) begin
      dummy = q.pop_front();
      m_cc = m_cc + 1;
      busy_until = cyc_n + CHARC + 1;
    end
    if (r && w && o == 6'd2) begin
      m_en = d[0];
      if (d[1]) m_ovf = 1'b0;
    end
    if (r && w && o == 6'd0 && b[0]) begin
      if (q.size() < DEPTH) q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    cyc_n++;
    @(posedge clk);
    #1;
    obs_v = rvalid; obs_d = rdata; obs_e = err;
  endtask

  task automatic rd(input logic [5:0] o);
    cyc(1'b1, 1'b0, mk_addr(o), 4'hf, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    q.delete();
    m_ovf = 1'b0; m_en = 1'b1; m_cc = 32'h0;
    cyc_n++;
    busy_until = cyc_n;
    exp_v = 1'b0; exp_d = 32'h0; exp_e = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rvalid=%b rdata=%h err=%b, expected 0/00000000/0", rvalid, rdata, err);
    end
    rd(6'd1);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== exp_d || obs_e !== exp_e || exp_d !== 32'h2) begin
      errors++;
      $display("FAIL reset_status: got v=%b d=%h e=%b, expected v=1 d=%h e=%b", obs_v, obs_d, obs_e, exp_d, exp_e);
    end
    rd(6'd2);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== exp_d || obs_e !== exp_e) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b d=%h e=%b, expected v=1 d=%h e=%b", obs_v, obs_d, obs_e, exp_d, exp_e);
    end
  endtask

  task automatic test_single_char();
    cyc(1'b1, 1'b1, mk_addr(6'd0), 4'h1, 32'h41);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== 32'h0 || obs_e !== 1'b0) begin
      errors++;
      $display("FAIL txdata_write_resp: got v=%b d=%h e=%b, expected v=1 d=00000000 e=0", obs_v, obs_d, obs_e);
    end
    for (int i = 0; i < 3; i++) begin
      rd(6'd1);
      checks++;
      if (obs_v !== 1'b1 || obs_d !== exp_d || obs_e !== exp_e) begin
        errors++;
        $display("FAIL single_status_%0d: got d=%h e=%b, expected d=%h e=%b", i, obs_d, obs_e, exp_d, exp_e);
      end
    end
    idle(CHARC);
    rd(6'd1);
    checks++;
    if (obs_d !== exp_d || obs_e !== exp_e) begin
      errors++;
      $display("FAIL single_idle_status: got d=%h, expected d=%h", obs_d, exp_d);
    end
    rd(6'd3);
    checks++;
    if (obs_d !== exp_d || exp_d !== 32'h1) begin
      errors++;
      $display("FAIL single_charcnt: got d=%h, expected d=%h", obs_d, exp_d);
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 1'b1, mk_addr(6'd2), 4'hf, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 1'b1, mk_addr(6'd0), 4'h1, $urandom);
    rd(6'd1);
    checks++;
    if (obs_d !== exp_d || exp_d !== 32'h0000_1009) begin
      errors++;
      $display("FAIL overflow_status: got d=%h, expected d=%h", obs_d, exp_d);
    end
    cyc(1'b1, 1'b1, mk_addr(6'd2), 4'hf, 32'h3);
    rd(6'd1);
    checks++;
    if (obs_d !== exp_d) begin
      errors++;
      $display("FAIL overflow_cleared: got d=%h, expected d=%h", obs_d, exp_d);
    end
    for (int i = 0; i < DEPTH; i++) begin
      idle(CHARC - 1);
      rd(6'd1);
      checks++;
      if (obs_d !== exp_d) begin
        errors++;
        $display("FAIL drain_status_%0d: got d=%h, expected d=%h", i, obs_d, exp_d);
      end
    end
    idle(2 * CHARC);
    rd(6'd3);
    checks++;
    if (obs_d !== exp_d || exp_d !== 32'd17) begin
      errors++;
      $display("FAIL drain_charcnt: got d=%h, expected d=%h", obs_d, exp_d);
    end
  endtask

  task automatic test_bad_offset();
    rd(6'h04);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== 32'h0 || obs_e !== 1'b1) begin
      errors++;
      $display("FAIL bad_read: got v=%b d=%h e=%b, expected v=1 d=00000000 e=1", obs_v, obs_d, obs_e);
    end
    cyc(1'b1, 1'b1, mk_addr(6'h10), 4'hf, $urandom);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== 32'h0 || obs_e !== 1'b1) begin
      errors++;
      $display("FAIL bad_write: got v=%b d=%h e=%b, expected v=1 d=00000000 e=1", obs_v, obs_d, obs_e);
    end
    rd(6'd1);
    checks++;
    if (obs_d !== exp_d || obs_e !== 1'b0) begin
      errors++;
      $display("FAIL bad_no_change: got d=%h e=%b, expected d=%h e=0", obs_d, obs_e, exp_d);
    end
  endtask

  task automatic test_be();
    cyc(1'b1, 1'b1, mk_addr(6'd0), 4'($urandom) & 4'he, $urandom);
    rd(6'd1);
    checks++;
    if (obs_d !== exp_d || obs_d[15:8] !== 8'h0) begin
      errors++;
      $display("FAIL be_no_push: got d=%h, expected d=%h", obs_d, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      rd(6'($urandom_range(0, 3)));
      checks++;
      if (obs_v !== 1'b1 || obs_d !== exp_d || obs_e !== exp_e) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b d=%h e=%b, expected v=1 d=%h e=%b", i, obs_v, obs_d, obs_e, exp_d, exp_e);
      end
    end
    idle(1);
    checks++;
    if (obs_v !== 1'b0 || obs_d !== exp_d || obs_e !== exp_e) begin
      errors++;
      $display("FAIL b2b_hold: got v=%b d=%h e=%b, expected v=0 d=%h e=%b", obs_v, obs_d, obs_e, exp_d, exp_e);
    end
  endtask

  task automatic test_random();
    int op;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      d = $urandom;
      case (op)
        0, 1, 2, 3: cyc(1'b1, 1'b1, mk_addr(6'd0), (op == 3) ? 4'(d[31:28]) : 4'hf, d);
        4, 5:       cyc(1'b1, 1'b0, mk_addr(6'($urandom_range(0, 3))), 4'hf, d);
        6:          cyc(1'b1, 1'b1, mk_addr(6'd2), 4'hf,
                        {30'h0, d[1], ($urandom_range(0, 3) != 0)});
        7:          idle($urandom_range(1, 15));
        8:          cyc(1'b1, d[0], mk_addr(6'($urandom_range(4, 63))), 4'hf, d);
        default:    rd(6'd1);
      endcase
      checks++;
      if (obs_v !== exp_v || obs_d !== exp_d || obs_e !== exp_e) begin
        errors++;
        $display("FAIL random_%0d op%0d: got v=%b d=%h e=%b, expected v=%b d=%h e=%b",
                 i, op, obs_v, obs_d, obs_e, exp_v, exp_d, exp_e);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    cyc(1'b1, 1'b1, mk_addr(6'd2), 4'hf, 32'h3);
    idle(DEPTH * CHARC + CHARC);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, mk_addr(6'd0), 4'h1, $urandom);
    idle(3);
    do_reset();
    rd(6'd1);
    checks++;
    if (obs_d !== exp_d || exp_d !== 32'h2) begin
      errors++;
      $display("FAIL midreset_status: got d=%h, expected d=%h", obs_d, exp_d);
    end
    rd(6'd3);
    checks++;
    if (obs_d !== exp_d || exp_d !== 32'h0) begin
      errors++;
      $display("FAIL midreset_charcnt: got d=%h, expected d=%h", obs_d, exp_d);
    end
    rd(6'd2);
    checks++;
    if (obs_d !== exp_d || exp_d !== 32'h1) begin
      errors++;
      $display("FAIL midreset_ctrl: got d=%h, expected d=%h", obs_d, exp_d);
    end
  endtask

  initial begin
    cyc_n = 0;
    busy_until = 0;
    resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_char();
    test_overflow();
    test_bad_offset();
    test_be();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
